// File: rtl/online_r4_pkg.sv
// Shared definitions for the radix-4 online arithmetic blocks (adder,
// on-the-fly converter, and future multiplier). Digits are signed 3-bit
// values in {-3..3}; the code 3'b100 (-4) is never legal.
package online_r4_pkg;

    // Radix and redundancy factor of the digit set.
    localparam int R  = 4;
    localparam int A  = 3;

    // Digit width and legal digit range.
    localparam int DW = 3;
    localparam logic signed [DW-1:0] DIG_MIN     = -3'sd3;
    localparam logic signed [DW-1:0] DIG_MAX     = 3'sd3;
    localparam logic        [DW-1:0] DIG_ILLEGAL = 3'b100;

    // Word-framing state shared by the online blocks.
    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // True for the single code outside the legal digit set.
    function automatic logic is_illegal_digit(input logic [DW-1:0] d);
        return (d == DIG_ILLEGAL);
    endfunction

endpackage

// File: rtl/otf_step_r4.sv
// Single-digit on-the-fly conversion step for radix 4.
// Given Q, QM (= Q-1) and a signed digit d in {-3..3}, produces the
// registers after appending d:
//   d>0 : Q' = 4Q  + d,     QM' = 4Q  + (d-1)
//   d=0 : Q' = 4Q,          QM' = 4QM + 3
//   d<0 : Q' = 4QM + (4+d), QM' = 4QM + (3+d)
// All arithmetic is modulo 2^OW, so each update is a 2-bit left shift
// followed by appending a 2-bit value; no carry chain is needed.
module otf_step_r4 #(
    parameter int OW = 9
) (
    input  logic [OW-1:0]     q,
    input  logic [OW-1:0]     qm,
    input  logic signed [2:0] d,
    output logic [OW-1:0]     q_nxt,
    output logic [OW-1:0]     qm_nxt
);

    // The appended 2-bit values: d mod 4 for Q and (d-1) mod 4 for QM.
    // For negative d these equal (4+d) and (3+d) respectively.
    logic [1:0] app_q;
    logic [1:0] app_qm;

    assign app_q  = d[1:0];
    assign app_qm = d[1:0] - 2'd1;

    // Select the shifted source register by digit sign, then append.
    always_comb begin
        q_nxt  = {q[OW-3:0], app_q};
        qm_nxt = {q[OW-3:0], app_qm};
        if (d == 3'sd0) begin
            q_nxt  = {q[OW-3:0], 2'b00};
            qm_nxt = {qm[OW-3:0], 2'b11};
        end else if (d < 3'sd0) begin
            q_nxt  = {qm[OW-3:0], app_q};
            qm_nxt = {qm[OW-3:0], app_qm};
        end
    end

endmodule

// File: rtl/online_otf_converter_r4.sv
// Converts an MSD-first stream of signed radix-4 digits into a
// two's-complement integer, one result per NDIG-digit word, using
// on-the-fly conversion. Malformed streams raise sticky error flags.
//
// Output handshake: q_out is meaningful only while out_valid=1. A result
// transfers on every rising edge where out_valid & out_ready are both 1.
// While out_valid=1, q_out stays stable until that transfer. A new result
// may load on the same edge as a transfer; a result completing while an
// untransferred one is still held is dropped and flagged via ovf_err.
// The digit input has no back-pressure: every en=1 cycle is consumed.
module online_otf_converter_r4 #(
    parameter int NDIG = 8,
    parameter int DW   = 3,
    parameter int OW   = 2*NDIG+1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          first,
    input  logic [DW-1:0] d_in,
    input  logic          out_ready,
    output logic [OW-1:0] q_out,
    output logic          out_valid,
    output logic          sync_err,
    output logic          dig_err,
    output logic          ovf_err
);

    import online_r4_pkg::*;

    localparam int CW = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [OW-1:0] q;
    logic [OW-1:0] qm;

    logic              illegal;
    logic signed [2:0] d_eff;
    logic [OW-1:0]     base_q;
    logic [OW-1:0]     base_qm;
    logic [OW-1:0]     q_nxt;
    logic [OW-1:0]     qm_nxt;
    logic              completes;

    // Illegal digit code is replaced by zero so the word still converts.
    always_comb begin
        illegal = is_illegal_digit(d_in);
        d_eff   = illegal ? 3'sd0 : $signed(d_in[2:0]);
    end

    // A leading digit restarts from (0, -1); otherwise continue the word.
    always_comb begin
        base_q  = q;
        base_qm = qm;
        if (first) begin
            base_q  = '0;
            base_qm = '1;
        end
    end

    otf_step_r4 #(
        .OW(OW)
    ) u_step (
        .q      (base_q),
        .qm     (base_qm),
        .d      (d_eff),
        .q_nxt  (q_nxt),
        .qm_nxt (qm_nxt)
    );

    // The NDIG-th digit of a word is a non-leading digit accepted in CONV
    // when NDIG-1 digits have already been counted.
    always_comb begin
        completes = en && !first && (state == CONV) && (count == LAST_CNT);
    end

    // Framing FSM, Q/QM registers, output register and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            q         <= '0;
            qm        <= '1;
            q_out     <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            dig_err   <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            // Consumer takes the held result.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (en && illegal) begin
                dig_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (en && first) begin
                        q     <= q_nxt;
                        qm    <= qm_nxt;
                        count <= CW'(1);
                        state <= CONV;
                    end else if (en) begin
                        // Continuation digit with no word in progress.
                        sync_err <= 1'b1;
                    end
                end
                CONV: begin
                    if (en && first) begin
                        // Abort the partial word and start a fresh one.
                        sync_err <= 1'b1;
                        q        <= q_nxt;
                        qm       <= qm_nxt;
                        count    <= CW'(1);
                    end else if (completes) begin
                        q     <= q_nxt;
                        qm    <= qm_nxt;
                        count <= '0;
                        state <= IDLE;
                        if (out_valid && !out_ready) begin
                            ovf_err <= 1'b1;
                        end else begin
                            q_out     <= q_nxt;
                            out_valid <= 1'b1;
                        end
                    end else if (en) begin
                        q     <= q_nxt;
                        qm    <= qm_nxt;
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/online_otf_converter_r4.md
# online_otf_converter_r4

Downstream stage of the radix-4 online adder: consumes the MSD-first stream of signed radix-4 digits it emits and converts each word to a conventional two's-complement integer using on-the-fly conversion (Q/QM registers), so no carry-propagate addition is needed. Each word of `NDIG` digits produces one result, held in a valid/ready output register for the next conventional-arithmetic stage. Malformed streams are flagged through sticky error bits.

## Interface
- `NDIG`, 8, digits per word (≥2)
- `DW`, 3, digit width (signed, fixed to 3 for radix 4)
- `OW`, 2*NDIG+1, result width (derived; do not override)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `en`  in  1  digit valid; `d_in` is consumed on every edge where `en`=1
- `first`  in  1  qualifies `d_in` as the most significant digit of a new word
- `d_in`  in  3  signed digit, legal set {-3..3}
- `out_ready`  in  1  consumer accepts `q_out`
- `q_out`  out  OW  signed result = Σ d_j·4^(NDIG-j), j=1..NDIG
- `out_valid`  out  1  `q_out` holds an unconsumed result
- `sync_err`  out  1  sticky: framing error
- `dig_err`  out  1  sticky: illegal digit (3'b100) received
- `ovf_err`  out  1  sticky: result lost to back-pressure

## Operation
- Reset values: `q_out`=0, `out_valid`=0, all error bits 0, Q=0, QM=−1 (all ones), count=0, state IDLE.
- FSM: IDLE → CONV on `en & first`; CONV → IDLE when the NDIG-th digit is accepted; CONV stays CONV otherwise.
- `en & first` in either state: Q,QM reinitialised from (0,−1) then updated with `d_in`; count=1. In CONV this aborts the partial word and sets `sync_err`.
- `en & !first` in IDLE: digit ignored, `sync_err` set.
- OTF update per accepted digit d (all arithmetic modulo 2^OW, shift left 2 and append 2 bits):
  - d>0: Q←4Q+d, QM←4Q+(d−1)
  - d=0: Q←4Q, QM←4QM+3
  - d<0: Q←4QM+(4+d), QM←4QM+(3+d)
- Invariant QM=Q−1; appended values always in 0..3. Result magnitude ≤4^NDIG−1 fits OW bits.
- `d_in`=3'b100: treated as 0, `dig_err` set; counting continues.
- Word completion: final Q (including last digit) loaded into `q_out`, `out_valid`←1.
- Output handshake: transfer on `out_valid & out_ready`; `out_valid` clears unless a new result loads the same edge (then stays 1 with new value).
- Completion while `out_valid`=1 and `out_ready`=0: new result dropped, `q_out` unchanged, `ovf_err` set.
- Error bits cleared only by `reset`.
- `en`=0 holds all conversion state; gaps between digits allowed.

## Timing
- Digit accepted at edge k updates Q/QM at edge k.
- Last digit at edge k → `out_valid`=1 and `q_out` valid from edge k (latency 1 cycle after last digit presented).
- Back-to-back words: `first` on the cycle right after the last digit is legal; sustained throughput one digit/cycle.
- `reset` asserted mid-word or with `out_valid`=1: everything returns to reset values at that edge; no partial result emitted.
- No input back-pressure: upstream adder cannot stall.

## Structure
- Shared package `online_r4_pkg`: `R`=4, `A`=3, `DW`=3, digit min/max constants, illegal-digit code, FSM state enum (IDLE, CONV). The adder and this block both import it.
- Sub-module `otf_step_r4`: combinational single-digit Q/QM update (inputs Q, QM, d; outputs Q', QM'), parameterised by OW, reusable by the future online multiplier output.

## Test plan
- NDIG=4, digits 1,0,0,0 (first on digit 1), out_ready=1 → `q_out`=64, `out_valid` one cycle.
- Digits −1,3,0,2 → −14; digits 3,3,3,3 → 255; digits −3,−3,−3,−3 → −256+1=−255; no error bits.
- Two back-to-back words with out_ready=0 throughout → first result (64) held, second dropped, `ovf_err`=1; then out_ready=1 → one transfer, `out_valid`=0.
- `first` asserted on digit 3 of a word, followed by 2,0,0,0 → `sync_err`=1, `q_out`=128.
- Digit 3'b100 within 1,4'h?→ sequence 1,−4,0,0 → `dig_err`=1, `q_out`=64.
- `reset` after 2 digits, then full word 0,0,1,1 → `q_out`=5, no residue from aborted word, errors 0.
